// File: rtl/priority_arbiter.sv
// priority_arbiter: single-owner arbiter over WIDTH request channels.
// Fixed-priority (lowest index wins) or round-robin selection, with an
// optional hold limit that revokes a grant after MAX_HOLD cycles.
// The owner-done input is named release_grant because "release" is a
// reserved word in SystemVerilog.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; grants=0; arbitrates when enable=1 and eligible != 0
// HOLD  | one channel owns the grant; ends on release, request drop, or
//       | hold-limit expiry; always returns through IDLE (dead cycle)
module priority_arbiter #(
  parameter int WIDTH    = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 255,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mode_rr,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] requests,
  input  logic             release_grant,
  output logic [WIDTH-1:0] grants,
  output logic [IDX_W-1:0] grant_idx,
  output logic             granted,
  output logic             timeout
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam bit             HOLD_LIMITED = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] PTR_RESET  = IDX_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] grants_d;
  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_d;

  logic [WIDTH-1:0] eligible;
  logic [IDX_W-1:0] fix_idx, rr_idx, win_idx;
  logic             expire;

  assign eligible = requests & ~mask;
  assign granted  = |(grants & requests);
  assign win_idx  = mode_rr ? rr_idx : fix_idx;
  assign expire   = HOLD_LIMITED && (cnt_q == HOLD_LAST);

  // Fixed priority: scan downward so the lowest eligible index is kept last.
  always_comb begin
    fix_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (eligible[i]) fix_idx = IDX_W'(i);
    end
  end

  // Round-robin: offsets WIDTH..1 above the pointer, smallest offset kept,
  // so the pointer's own channel (offset WIDTH) is the last resort.
  always_comb begin
    rr_idx = '0;
    for (int i = WIDTH; i >= 1; i--) begin
      int c;
      c = int'(ptr_q) + i;
      if (c >= WIDTH) c = c - WIDTH;
      if (eligible[c]) rr_idx = IDX_W'(c);
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d   = state_q;
    grants_d  = grants;
    idx_d     = grant_idx;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && (eligible != '0)) begin
          state_d           = HOLD;
          grants_d          = '0;
          grants_d[win_idx] = 1'b1;
          idx_d             = win_idx;
          ptr_d             = win_idx;
          cnt_d             = '0;
        end
      end
      HOLD: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (release_grant || !granted || expire) begin
          state_d   = IDLE;
          grants_d  = '0;
          idx_d     = '0;
          cnt_d     = '0;
          // Revocation is only reported when the limit alone ended the grant.
          timeout_d = expire && !release_grant && granted;
        end
      end
      default: begin
        state_d  = IDLE;
        grants_d = '0;
        idx_d    = '0;
        cnt_d    = '0;
      end
    endcase
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grants    <= '0;
      grant_idx <= '0;
      ptr_q     <= PTR_RESET;
      cnt_q     <= '0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grants    <= grants_d;
      grant_idx <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_priority_arbiter.sv
// Bench for priority_arbiter (WIDTH=8, MAX_HOLD=4). Each vector is applied
// for one cycle; its expected outputs are queued and checked one cycle later.
module tb_priority_arbiter;

  localparam int WIDTH    = 8;
  localparam int IDX_W    = 3;
  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             mode_rr = 1'b0;
  logic [WIDTH-1:0] mask = '0;
  logic [WIDTH-1:0] requests = '0;
  logic             release_grant = 1'b0;
  logic [WIDTH-1:0] grants;
  logic [IDX_W-1:0] grant_idx;
  logic             granted;
  logic             timeout;

  priority_arbiter #(
    .WIDTH(WIDTH), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode_rr(mode_rr), .mask(mask),
    .requests(requests), .release_grant(release_grant), .grants(grants),
    .grant_idx(grant_idx), .granted(granted), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, en, rr;
    logic [7:0] m, q;
    logic       rel;
    logic [7:0] g;
    logic [2:0] idx;
    logic       to;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] g;
    logic [2:0] idx;
    logic       to;
    logic [7:0] q;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_id   = 0;

  function automatic vec_t mk(logic r, logic en, logic rr, logic [7:0] m,
                              logic [7:0] q, logic rel, logic [7:0] g,
                              logic [2:0] idx, logic to);
    vec_t v;
    v.r = r; v.en = en; v.rr = rr; v.m = m; v.q = q; v.rel = rel;
    v.g = g; v.idx = idx; v.to = to;
    return v;
  endfunction

  task automatic cmp(string name, int id, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, id, act, req);
    end
  endtask

  task automatic check_head();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    cmp("grants", e.id, 32'(grants), 32'(e.g));
    cmp("grant_idx", e.id, 32'(grant_idx), 32'(e.idx));
    cmp("timeout", e.id, 32'(timeout), 32'(e.to));
    cmp("granted", e.id, 32'(granted), 32'(|(e.g & e.q)));
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    @(negedge clk);
    check_head();
    rst = v.r; enable = v.en; mode_rr = v.rr; mask = v.m;
    requests = v.q; release_grant = v.rel;
    e.id = vec_id; e.g = v.g; e.idx = v.idx; e.to = v.to; e.q = v.q;
    sb.push_back(e);
    vec_id++;
  endtask

  initial begin
    // reset
    tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 8'hFF, 0, 8'h00, 0, 0));
    // fixed priority, release, re-grant, request drop
    tbl.push_back(mk(0, 1, 0, 8'h00, 8'h2C, 0, 8'h04, 2, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 8'h2C, 1, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 8'h2C, 0, 8'h04, 2, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0));
    // everything masked: no grant
    tbl.push_back(mk(0, 1, 0, 8'hFF, 8'hFF, 0, 8'h00, 0, 0));
    // mask excludes ch0; mask/mode/enable changes during HOLD are ignored
    tbl.push_back(mk(0, 1, 0, 8'h01, 8'h03, 0, 8'h02, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'h02, 8'h03, 0, 8'h02, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'hFF, 8'h03, 0, 8'h02, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 8'h03, 1, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h03, 0, 8'h00, 0, 0));
    // round-robin full sweep from reset pointer
    tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0));
    for (int k = 0; k < 9; k++) begin
      logic [7:0] oh;
      oh = 8'h01 << (k % 8);
      tbl.push_back(mk(0, 1, 1, 8'h00, 8'hFF, 0, oh, 3'(k % 8), 0));
      tbl.push_back(mk(0, 1, 1, 8'h00, 8'hFF, 1, 8'h00, 0, 0));
    end
    // round-robin wrap between channels 0 and 7
    tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 8'h81, 0, 8'h01, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 8'h81, 1, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 8'h81, 0, 8'h80, 7, 0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 8'h81, 1, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 8'h81, 0, 8'h01, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 8'h81, 1, 8'h00, 0, 0));
    // release in IDLE does not block arbitration
    tbl.push_back(mk(0, 1, 0, 8'h00, 8'h08, 1, 8'h08, 3, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 8'h08, 1, 8'h00, 0, 0));
    // fixed-mode winner updates the pointer; it carries into RR mode
    tbl.push_back(mk(0, 1, 0, 8'h00, 8'hC0, 0, 8'h40, 6, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 8'hC0, 1, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 8'hC1, 0, 8'h80, 7, 0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 8'hC1, 1, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 8'hC1, 0, 8'h01, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 8'hC1, 1, 8'h00, 0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // hold limit: 4 cycles of grant, timeout pulse, dead cycle, re-grant
    apply(mk(0, 1, 0, 8'h00, 8'h10, 0, 8'h10, 4, 0));
    for (int k = 0; k < 3; k++) apply(mk(0, 1, 0, 8'h00, 8'h10, 0, 8'h10, 4, 0));
    apply(mk(0, 1, 0, 8'h00, 8'h10, 0, 8'h00, 0, 1));
    apply(mk(0, 1, 0, 8'h00, 8'h10, 0, 8'h10, 4, 0));
    for (int k = 0; k < 3; k++) apply(mk(0, 1, 0, 8'h00, 8'h10, 0, 8'h10, 4, 0));
    // release on the expiry cycle suppresses timeout
    apply(mk(0, 1, 0, 8'h00, 8'h10, 1, 8'h00, 0, 0));
    apply(mk(0, 1, 0, 8'h00, 8'h10, 0, 8'h10, 4, 0));
    for (int k = 0; k < 3; k++) apply(mk(0, 1, 0, 8'h00, 8'h10, 0, 8'h10, 4, 0));
    // request drop on the expiry cycle suppresses timeout
    apply(mk(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0));
    apply(mk(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0));

    // reset mid-HOLD, then RR restarts at channel 0
    apply(mk(0, 1, 0, 8'h00, 8'h20, 0, 8'h20, 5, 0));
    apply(mk(1, 1, 0, 8'h00, 8'h20, 0, 8'h00, 0, 0));
    apply(mk(0, 1, 1, 8'h00, 8'hFF, 0, 8'h01, 0, 0));
    apply(mk(0, 1, 1, 8'h00, 8'hFF, 1, 8'h00, 0, 0));

    // reset on the expiry cycle: no timeout pulse
    apply(mk(0, 1, 0, 8'h00, 8'h04, 0, 8'h04, 2, 0));
    for (int k = 0; k < 3; k++) apply(mk(0, 1, 0, 8'h00, 8'h04, 0, 8'h04, 2, 0));
    apply(mk(1, 1, 0, 8'h00, 8'h04, 0, 8'h00, 0, 0));
    apply(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0));

    @(negedge clk);
    check_head();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
